ddr3_axi_arbiter: RTL and testbench
===================================

DDR3_AXI_ARBITER -- requirements
Module: ddr3_axi_arbiter

Interface
REQ-001 SHALL have parameters: MID_W default 3, master ID width; ADDR_W default 30, byte address width; DATA_W default 64, data width.
REQ-002 SHALL have port clk_clk, input, 1, the single clock for all logic; this is the DDR3 AXI controller half-rate AFI clock.
REQ-003 SHALL have port reset_reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have, for each m0_*/m1_*, AW inputs awid MID_W, awaddr ADDR_W, awlen 8, awsize 3, awburst 2, awvalid 1, plus output awready 1.
REQ-005 SHALL have, for each m0_*/m1_*, W inputs wdata DATA_W, wstrb DATA_W/8, wlast 1, wvalid 1, plus output wready 1.
REQ-006 SHALL have, for each m0_*/m1_*, B outputs bid MID_W, bresp 2, bvalid 1, plus input bready 1.
REQ-007 SHALL have, for each m0_*/m1_*, the AR group mirroring AW, and the R group: outputs rid MID_W, rdata DATA_W, rresp 2, rlast 1, rvalid 1, plus input rready 1.
REQ-008 SHALL have s_* ports, one AXI4 master bundle toward the DDR3 slave, with IDs of MID_W+1 bits and the same field widths; s_awlock/s_arlock are tied 0, cache 4'b0011, prot 0, qos 0.
REQ-009 SHALL have port err_wlast, output, 1, sticky flag set on a master wlast/awlen mismatch.

Function
REQ-010 Write FSM SHALL have states W_IDLE, W_ADDR and W_DATA.
REQ-011 In W_IDLE with any mX_awvalid, the FSM SHALL assert that master's awready combinationally, capture its AW fields into a holding register at the clock edge, and go to W_ADDR.
REQ-012 In W_ADDR, s_awvalid SHALL be 1 from the register, with s_awid = {grant, awid}; on s_awready the FSM SHALL go to W_DATA.
REQ-013 In W_DATA, W SHALL be muxed from the granted master only; the other master's wready SHALL be 0; s_wlast SHALL be generated from an 8-bit beat counter (beat == awlen).
REQ-014 On the s_wlast handshake the write FSM SHALL return to W_IDLE; a new AW grant SHALL NOT occur in W_ADDR or W_DATA (one write burst at a time).
REQ-015 If the master's wlast differs from the generated s_wlast on any beat, err_wlast SHALL be set; the data SHALL be forwarded unchanged.
REQ-016 Read FSM SHALL have states R_IDLE and R_ADDR, with the same capture and forward behaviour and s_arid = {grant, arid}; reads SHALL NOT be locked to data completion.
REQ-017 Arbitration SHALL be two-way round-robin, with the write and read pointers kept separately; both at reset SHALL favour m0.
REQ-018 After a grant to master k, priority SHALL pass to the other master; with a single requester, that requester SHALL win regardless of the pointer.
REQ-019 R and B routing SHALL be combinational on s_rid/s_bid MSB: mX_rvalid = s_rvalid & (MSB==X), s_rready = the selected rready, and the returned ID SHALL be the lower MID_W bits.
REQ-020 Latency SHALL be: m_awvalid/arvalid in cycle N gives awready/arready in cycle N and s_awvalid/arvalid in cycle N+1.
REQ-021 Write and read paths SHALL operate independently; simultaneous AW and AR grants in the same cycle SHALL be legal.

Reset
REQ-022 During reset, all FSMs SHALL be IDLE, all valid/ready outputs 0, pointers favouring m0, the beat counter 0, err_wlast 0, and holding registers 0.
REQ-023 Reset asserted mid-burst SHALL abort without completion; the integrator SHALL reset the DDR3 slave in the same window (driven from afi_reset_reset_n).

Structure
REQ-024 A shared package ddr3_axi_arb_pkg SHALL hold the width constants, the AXI tie-off constants (cache, prot, qos, lock) and the write/read state enums.
REQ-025 The sub-module axi_rr_arb2 (request[1:0], advance, grant, grant_valid, with an internal pointer) SHALL be instantiated twice: once for AW and once for AR.

Verification
REQ-026 Both awvalid asserted at the same time after reset, each with awlen=3 -> m0 granted first, s_awid=4'b0xxx, 4 beats with s_wlast on beat 4; then m1 granted, s_awid=4'b1xxx.
REQ-027 m1 sends wvalid before its AW is granted while m0 owns W -> m1_wready stays 0 until m0's last beat handshakes.
REQ-028 s_rid=4'b1010 with s_rvalid=1 -> m1_rvalid=1, m1_rid=3'b010, m0_rvalid=0, and s_rready follows m1_rready.
REQ-029 m0 issues awlen=1 but asserts wlast on beat 1 -> err_wlast=1 and stays 1 until reset; s_wlast is asserted on beat 2.
REQ-030 reset_reset_n deasserted in W_DATA mid-burst -> all outputs 0 immediately (asynchronous), FSM in W_IDLE, and the next grant favours m0.

Source files
------------

// File: rtl/ddr3_axi_arb_pkg.sv
// Shared constants and state types for the two-master DDR3 AXI arbiter.
package ddr3_axi_arb_pkg;

    localparam int MID_W_DEF  = 3;
    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 64;

    // Fixed AXI attributes presented to the DDR3 controller.
    localparam logic       AXI_LOCK  = 1'b0;
    localparam logic [3:0] AXI_CACHE = 4'b0011;
    localparam logic [2:0] AXI_PROT  = 3'b000;
    localparam logic [3:0] AXI_QOS   = 4'b0000;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_ADDR
    } rd_state_e;

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips to the loser after each advanced grant.
module axi_rr_arb2
    import ddr3_axi_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] request,
    input  logic       advance,
    output logic       grant,
    output logic       grant_valid
);

    logic ptr_q, ptr_d;

    // ptr_q == 0 favours request[0]; a lone requester always wins.
    always_comb begin
        grant       = request[1] & (~request[0] | ptr_q);
        grant_valid = |request;
        ptr_d       = ptr_q;
        if (advance && grant_valid) begin
            ptr_d = ~grant;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ddr3_axi_arbiter.sv
// Merges two AXI4 masters onto one DDR3 AXI port: one write burst at a time, reads
// forwarded address-only, responses routed back by the ID MSB.
module ddr3_axi_arbiter
    import ddr3_axi_arb_pkg::*;
#(
    parameter int MID_W  = MID_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [MID_W-1:0]    m0_awid,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [7:0]          m0_awlen,
    input  logic [2:0]          m0_awsize,
    input  logic [1:0]          m0_awburst,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wlast,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    output logic [MID_W-1:0]    m0_bid,
    output logic [1:0]          m0_bresp,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    input  logic [MID_W-1:0]    m0_arid,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [MID_W-1:0]    m0_rid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic [MID_W-1:0]    m1_awid,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [MID_W-1:0]    m1_bid,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    input  logic [MID_W-1:0]    m1_arid,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [MID_W-1:0]    m1_rid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [MID_W:0]      s_awid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic                s_awlock,
    output logic [3:0]          s_awcache,
    output logic [2:0]          s_awprot,
    output logic [3:0]          s_awqos,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [MID_W:0]      s_bid,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic [MID_W:0]      s_arid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    output logic                s_arlock,
    output logic [3:0]          s_arcache,
    output logic [2:0]          s_arprot,
    output logic [3:0]          s_arqos,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [MID_W:0]      s_rid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic                err_wlast
);

    wr_state_e           wr_state_q, wr_state_d;
    rd_state_e           rd_state_q, rd_state_d;
    logic                aw_grant, aw_gvalid, aw_take;
    logic                ar_grant, ar_gvalid, ar_take;
    logic                aw_sel_q, aw_sel_d, ar_sel_q, ar_sel_d;
    logic [MID_W-1:0]    aw_id_q, aw_id_d, ar_id_q, ar_id_d;
    logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [7:0]          aw_len_q, aw_len_d, ar_len_q, ar_len_d;
    logic [2:0]          aw_size_q, aw_size_d, ar_size_q, ar_size_d;
    logic [1:0]          aw_burst_q, aw_burst_d, ar_burst_q, ar_burst_d;
    logic [7:0]          beat_q, beat_d;
    logic                err_q, err_d;
    logic                w_active, mst_wvalid, mst_wlast, w_fire;

    axi_rr_arb2 u_aw_arb (
        .clk_i       (clk_clk),
        .rst_ni      (reset_reset_n),
        .request     ({m1_awvalid, m0_awvalid}),
        .advance     (aw_take),
        .grant       (aw_grant),
        .grant_valid (aw_gvalid)
    );

    axi_rr_arb2 u_ar_arb (
        .clk_i       (clk_clk),
        .rst_ni      (reset_reset_n),
        .request     ({m1_arvalid, m0_arvalid}),
        .advance     (ar_take),
        .grant       (ar_grant),
        .grant_valid (ar_gvalid)
    );

    // Address-channel ready is gated by reset so nothing is accepted while held in reset.
    assign aw_take    = reset_reset_n & (wr_state_q == W_IDLE) & aw_gvalid;
    assign ar_take    = reset_reset_n & (rd_state_q == R_IDLE) & ar_gvalid;
    assign m0_awready = aw_take & ~aw_grant;
    assign m1_awready = aw_take & aw_grant;
    assign m0_arready = ar_take & ~ar_grant;
    assign m1_arready = ar_take & ar_grant;

    assign s_awvalid = (wr_state_q == W_ADDR);
    assign s_awid    = {aw_sel_q, aw_id_q};
    assign s_awaddr  = aw_addr_q;
    assign s_awlen   = aw_len_q;
    assign s_awsize  = aw_size_q;
    assign s_awburst = aw_burst_q;
    assign s_awlock  = AXI_LOCK;
    assign s_awcache = AXI_CACHE;
    assign s_awprot  = AXI_PROT;
    assign s_awqos   = AXI_QOS;
    assign s_arvalid = (rd_state_q == R_ADDR);
    assign s_arid    = {ar_sel_q, ar_id_q};
    assign s_araddr  = ar_addr_q;
    assign s_arlen   = ar_len_q;
    assign s_arsize  = ar_size_q;
    assign s_arburst = ar_burst_q;
    assign s_arlock  = AXI_LOCK;
    assign s_arcache = AXI_CACHE;
    assign s_arprot  = AXI_PROT;
    assign s_arqos   = AXI_QOS;

    // W is only ever connected to the master that owns the current burst.
    assign w_active   = (wr_state_q == W_DATA);
    assign mst_wvalid = aw_sel_q ? m1_wvalid : m0_wvalid;
    assign mst_wlast  = aw_sel_q ? m1_wlast : m0_wlast;
    assign s_wvalid   = w_active & mst_wvalid;
    assign s_wdata    = w_active ? (aw_sel_q ? m1_wdata : m0_wdata) : '0;
    assign s_wstrb    = w_active ? (aw_sel_q ? m1_wstrb : m0_wstrb) : '0;
    assign s_wlast    = w_active & (beat_q == aw_len_q);
    assign m0_wready  = w_active & ~aw_sel_q & s_wready;
    assign m1_wready  = w_active & aw_sel_q & s_wready;
    assign w_fire     = s_wvalid & s_wready;
    assign err_wlast  = err_q;

    assign m0_bid    = s_bid[MID_W-1:0];
    assign m1_bid    = s_bid[MID_W-1:0];
    assign m0_bresp  = s_bresp;
    assign m1_bresp  = s_bresp;
    assign m0_bvalid = reset_reset_n & s_bvalid & ~s_bid[MID_W];
    assign m1_bvalid = reset_reset_n & s_bvalid & s_bid[MID_W];
    assign s_bready  = reset_reset_n & (s_bid[MID_W] ? m1_bready : m0_bready);
    assign m0_rid    = s_rid[MID_W-1:0];
    assign m1_rid    = s_rid[MID_W-1:0];
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rlast  = s_rlast;
    assign m0_rvalid = reset_reset_n & s_rvalid & ~s_rid[MID_W];
    assign m1_rvalid = reset_reset_n & s_rvalid & s_rid[MID_W];
    assign s_rready  = reset_reset_n & (s_rid[MID_W] ? m1_rready : m0_rready);

    always_comb begin
        wr_state_d = wr_state_q;
        aw_sel_d   = aw_sel_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        beat_d     = beat_q;
        err_d      = err_q;
        case (wr_state_q)
            W_IDLE: if (aw_take) begin
                aw_sel_d   = aw_grant;
                aw_id_d    = aw_grant ? m1_awid : m0_awid;
                aw_addr_d  = aw_grant ? m1_awaddr : m0_awaddr;
                aw_len_d   = aw_grant ? m1_awlen : m0_awlen;
                aw_size_d  = aw_grant ? m1_awsize : m0_awsize;
                aw_burst_d = aw_grant ? m1_awburst : m0_awburst;
                wr_state_d = W_ADDR;
            end
            W_ADDR: if (s_awready) wr_state_d = W_DATA;
            W_DATA: if (w_fire) begin
                // The burst length comes from awlen; a disagreeing wlast is only flagged.
                if (mst_wlast != s_wlast) err_d = 1'b1;
                if (s_wlast) begin
                    beat_d     = 8'd0;
                    wr_state_d = W_IDLE;
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        ar_sel_d   = ar_sel_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        case (rd_state_q)
            R_IDLE: if (ar_take) begin
                ar_sel_d   = ar_grant;
                ar_id_d    = ar_grant ? m1_arid : m0_arid;
                ar_addr_d  = ar_grant ? m1_araddr : m0_araddr;
                ar_len_d   = ar_grant ? m1_arlen : m0_arlen;
                ar_size_d  = ar_grant ? m1_arsize : m0_arsize;
                ar_burst_d = ar_grant ? m1_arburst : m0_arburst;
                rd_state_d = R_ADDR;
            end
            R_ADDR: if (s_arready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            aw_sel_q   <= 1'b0;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            ar_sel_q   <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_sel_q   <= aw_sel_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            ar_sel_q   <= ar_sel_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_ddr3_axi_arbiter.sv
// Randomized bench for ddr3_axi_arbiter against a transaction-level model of grants, bursts and routing.
module tb_ddr3_axi_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [2:0]  m0_awid, m1_awid, m0_arid, m1_arid, m0_bid, m1_bid, m0_rid, m1_rid;
    logic [29:0] m0_awaddr, m1_awaddr, m0_araddr, m1_araddr;
    logic [7:0]  m0_awlen, m1_awlen, m0_arlen, m1_arlen;
    logic [2:0]  m0_awsize, m1_awsize, m0_arsize, m1_arsize;
    logic [1:0]  m0_awburst, m1_awburst, m0_arburst, m1_arburst;
    logic        m0_awvalid, m1_awvalid, m0_awready, m1_awready;
    logic [63:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [7:0]  m0_wstrb, m1_wstrb;
    logic        m0_wlast, m1_wlast, m0_wvalid, m1_wvalid, m0_wready, m1_wready;
    logic [1:0]  m0_bresp, m1_bresp, m0_rresp, m1_rresp;
    logic        m0_bvalid, m1_bvalid, m0_bready, m1_bready;
    logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic [3:0]  s_awid, s_arid, s_bid, s_rid;
    logic [29:0] s_awaddr, s_araddr;
    logic [7:0]  s_awlen, s_arlen, s_wstrb;
    logic [2:0]  s_awsize, s_arsize, s_awprot, s_arprot;
    logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic        s_awlock, s_arlock;
    logic [3:0]  s_awcache, s_arcache, s_awqos, s_arqos;
    logic        s_awvalid, s_awready, s_arvalid, s_arready;
    logic [63:0] s_wdata, s_rdata;
    logic        s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_rlast, s_rvalid, s_rready, err_wlast;

    int testsRun = 0;
    int testsFailed = 0;
    int favorW, favorR;
    bit errExp;

    ddr3_axi_arbiter dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
        .m0_awburst(m0_awburst), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid),
        .m0_wready(m0_wready), .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid),
        .m0_bready(m0_bready), .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid),
        .m0_arready(m0_arready), .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
        .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid),
        .m1_wready(m1_wready), .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid),
        .m1_bready(m1_bready), .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid),
        .m1_arready(m1_arready), .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
        .s_awqos(s_awqos), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .s_bready(s_bready), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache),
        .s_arprot(s_arprot), .s_arqos(s_arqos), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .err_wlast(err_wlast)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_clk = ~clk_clk;

    // Hard stop in case the whole run wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Quiet all bench-driven valids/readies.
    task automatic clearInputs();
        m0_awvalid = 0; m1_awvalid = 0; m0_arvalid = 0; m1_arvalid = 0;
        m0_wvalid = 0; m1_wvalid = 0; m0_wlast = 0; m1_wlast = 0;
        m0_bready = 0; m1_bready = 0; m0_rready = 0; m1_rready = 0;
        s_awready = 0; s_arready = 0; s_wready = 0; s_bvalid = 0; s_rvalid = 0;
        s_bid = 0; s_rid = 0; s_bresp = 0; s_rresp = 0; s_rlast = 0; s_rdata = 0;
        m0_wdata = 0; m1_wdata = 0; m0_wstrb = 0; m1_wstrb = 0;
    endtask

    // Present one master's AW and AR request fields.
    task automatic applyStimulus(input int m, input logic [2:0] id, input logic [29:0] addr,
                                 input logic [7:0] len, input logic [2:0] rid,
                                 input logic [29:0] raddr, input logic [7:0] rlen);
        if (m == 0) begin
            m0_awid = id; m0_awaddr = addr; m0_awlen = len; m0_awsize = 3'd3; m0_awburst = 2'd1;
            m0_arid = rid; m0_araddr = raddr; m0_arlen = rlen; m0_arsize = 3'd3; m0_arburst = 2'd1;
        end else begin
            m1_awid = id; m1_awaddr = addr; m1_awlen = len; m1_awsize = 3'd3; m1_awburst = 2'd1;
            m1_arid = rid; m1_araddr = raddr; m1_arlen = rlen; m1_arsize = 3'd3; m1_arburst = 2'd1;
        end
    endtask

    function automatic int pickWinner(input bit r0, input bit r1, input int favor);
        if (r0 && r1) return favor;
        return r1 ? 1 : 0;
    endfunction

    // Runs one write burst per master in awMask and one read address per master in arMask,
    // checking every cycle against the transaction model. fixedLen < 0 picks random lengths.
    task automatic runBursts(input logic [1:0] awMask, input logic [1:0] arMask,
                             input int fixedLen, input bit badLast);
        int          len[2], rlen[2], beat[2];
        logic [2:0]  id[2], rid[2];
        logic [29:0] addr[2], raddr[2];
        logic [63:0] dat[2][8];
        logic [7:0]  strb[2];
        bit          awPend[2], arPend[2], wv[2], wl[2];
        bit          wAddrPhase, wDataPhase, rAddrPhase;
        int          wOwner, rOwner, wWin, rWin, cycles;
        wAddrPhase = 0; wDataPhase = 0; rAddrPhase = 0;
        wOwner = -1; rOwner = -1; cycles = 0;
        for (int m = 0; m < 2; m++) begin
            len[m]    = (fixedLen >= 0) ? fixedLen : $urandom_range(0, 7);
            rlen[m]   = $urandom_range(0, 255);
            id[m]     = 3'($urandom);
            rid[m]    = 3'($urandom);
            addr[m]   = 30'($urandom);
            raddr[m]  = 30'($urandom);
            strb[m]   = 8'($urandom);
            beat[m]   = 0;
            awPend[m] = awMask[m];
            arPend[m] = arMask[m];
            for (int b = 0; b < 8; b++) dat[m][b] = {$urandom, $urandom};
            applyStimulus(m, id[m], addr[m], 8'(len[m]), rid[m], raddr[m], 8'(rlen[m]));
        end
        while ((awPend[0] || awPend[1] || arPend[0] || arPend[1] || wAddrPhase || wDataPhase
                || rAddrPhase) && cycles < 400) begin
            @(negedge clk_clk);
            cycles++;
            for (int m = 0; m < 2; m++) begin
                // A master still waiting for its AW grant pushes W early; it must be held off.
                wv[m] = (wDataPhase && wOwner == m) ? bit'($urandom_range(0, 1)) : awPend[m];
                wl[m] = badLast ? (beat[m] == 0) : (beat[m] == len[m]);
            end
            m0_awvalid = awPend[0]; m1_awvalid = awPend[1];
            m0_arvalid = arPend[0]; m1_arvalid = arPend[1];
            m0_wvalid = wv[0]; m0_wlast = wl[0]; m0_wdata = dat[0][beat[0]]; m0_wstrb = strb[0];
            m1_wvalid = wv[1]; m1_wlast = wl[1]; m1_wdata = dat[1][beat[1]]; m1_wstrb = strb[1];
            s_awready = 1'($urandom); s_arready = 1'($urandom); s_wready = 1'($urandom);
            s_rid = 4'($urandom); s_rvalid = 1'($urandom); s_rdata = {$urandom, $urandom};
            s_bid = 4'($urandom); s_bvalid = 1'($urandom); s_bresp = 2'($urandom);
            m0_rready = 1'($urandom); m1_rready = 1'($urandom);
            m0_bready = 1'($urandom); m1_bready = 1'($urandom);
            #1;
            wWin = (!wAddrPhase && !wDataPhase && (awPend[0] || awPend[1]))
                   ? pickWinner(awPend[0], awPend[1], favorW) : -1;
            rWin = (!rAddrPhase && (arPend[0] || arPend[1]))
                   ? pickWinner(arPend[0], arPend[1], favorR) : -1;
            checkOutput("m0_awready", m0_awready, wWin == 0);
            checkOutput("m1_awready", m1_awready, wWin == 1);
            checkOutput("m0_arready", m0_arready, rWin == 0);
            checkOutput("m1_arready", m1_arready, rWin == 1);
            checkOutput("s_awvalid", s_awvalid, wAddrPhase);
            checkOutput("s_arvalid", s_arvalid, rAddrPhase);
            if (wAddrPhase) begin
                checkOutput("s_awid", s_awid, {wOwner[0], id[wOwner]});
                checkOutput("s_awaddr", s_awaddr, addr[wOwner]);
                checkOutput("s_awlen", s_awlen, len[wOwner]);
                checkOutput("s_awsize", s_awsize, 3);
            end
            if (rAddrPhase) begin
                checkOutput("s_arid", s_arid, {rOwner[0], rid[rOwner]});
                checkOutput("s_araddr", s_araddr, raddr[rOwner]);
                checkOutput("s_arlen", s_arlen, rlen[rOwner]);
            end
            checkOutput("s_wvalid", s_wvalid, wDataPhase && wv[wOwner]);
            checkOutput("m0_wready", m0_wready, wDataPhase && wOwner == 0 && s_wready);
            checkOutput("m1_wready", m1_wready, wDataPhase && wOwner == 1 && s_wready);
            if (wDataPhase && wv[wOwner]) begin
                checkOutput("s_wdata", s_wdata, dat[wOwner][beat[wOwner]]);
                checkOutput("s_wstrb", s_wstrb, strb[wOwner]);
                checkOutput("s_wlast", s_wlast, beat[wOwner] == len[wOwner]);
            end
            checkOutput("m0_rvalid", m0_rvalid, s_rvalid && s_rid < 8);
            checkOutput("m1_rvalid", m1_rvalid, s_rvalid && s_rid >= 8);
            checkOutput("s_rready", s_rready, (s_rid >= 8) ? m1_rready : m0_rready);
            checkOutput("m0_rid", m0_rid, s_rid % 8);
            checkOutput("m1_rdata", m1_rdata, s_rdata);
            checkOutput("m0_bvalid", m0_bvalid, s_bvalid && s_bid < 8);
            checkOutput("m1_bvalid", m1_bvalid, s_bvalid && s_bid >= 8);
            checkOutput("s_bready", s_bready, (s_bid >= 8) ? m1_bready : m0_bready);
            checkOutput("m1_bid", m1_bid, s_bid % 8);
            checkOutput("m0_bresp", m0_bresp, s_bresp);
            // Advance the model by whatever handshakes the coming rising edge completes.
            if (wWin >= 0) begin
                awPend[wWin] = 0; wOwner = wWin; favorW = 1 - wWin; wAddrPhase = 1;
            end else if (wAddrPhase && s_awready) begin
                wAddrPhase = 0; wDataPhase = 1;
            end else if (wDataPhase && wv[wOwner] && s_wready) begin
                if (wl[wOwner] != (beat[wOwner] == len[wOwner])) errExp = 1;
                if (beat[wOwner] == len[wOwner]) begin
                    beat[wOwner] = 0; wDataPhase = 0; wOwner = -1;
                end else begin
                    beat[wOwner]++;
                end
            end
            if (rWin >= 0) begin
                arPend[rWin] = 0; rOwner = rWin; favorR = 1 - rWin; rAddrPhase = 1;
            end else if (rAddrPhase && s_arready) begin
                rAddrPhase = 0;
            end
        end
        checkOutput("burst completion within budget", cycles < 400, 1);
        @(negedge clk_clk);
        clearInputs();
        #1 checkOutput("err_wlast", err_wlast, errExp);
    endtask

    initial begin
        clearInputs();
        for (int m = 0; m < 2; m++) applyStimulus(m, 0, 0, 0, 0, 0, 0);
        reset_reset_n = 0;
        favorW = 0; favorR = 0; errExp = 0;
        m0_awvalid = 1; m1_arvalid = 1; s_rvalid = 1; s_rid = 4'b1000; m1_rready = 1;
        s_bvalid = 1; m0_bready = 1;
        repeat (2) @(negedge clk_clk);
        #1;
        checkOutput("reset m0_awready", m0_awready, 0);
        checkOutput("reset m1_arready", m1_arready, 0);
        checkOutput("reset s_awvalid", s_awvalid, 0);
        checkOutput("reset s_arvalid", s_arvalid, 0);
        checkOutput("reset s_wvalid", s_wvalid, 0);
        checkOutput("reset m1_rvalid", m1_rvalid, 0);
        checkOutput("reset s_rready", s_rready, 0);
        checkOutput("reset m0_bvalid", m0_bvalid, 0);
        checkOutput("reset err_wlast", err_wlast, 0);
        checkOutput("reset s_awaddr", s_awaddr, 0);
        @(negedge clk_clk);
        reset_reset_n = 1;
        clearInputs();
        #1;
        checkOutput("tie s_awcache", s_awcache, 4'b0011);
        checkOutput("tie s_arlock", s_arlock, 0);
        checkOutput("tie s_awqos", s_awqos, 0);

        // Both masters request awlen=3 together: m0 first, then m1; reads run alongside.
        runBursts(2'b11, 2'b11, 3, 0);

        @(negedge clk_clk);
        s_rid = 4'b1010; s_rvalid = 1; m1_rready = 1; m0_rready = 0;
        #1;
        checkOutput("route m1_rvalid", m1_rvalid, 1);
        checkOutput("route m1_rid", m1_rid, 3'b010);
        checkOutput("route m0_rvalid", m0_rvalid, 0);
        checkOutput("route s_rready hi", s_rready, 1);
        m1_rready = 0;
        #1 checkOutput("route s_rready lo", s_rready, 0);
        clearInputs();

        for (int i = 0; i < 40; i++) begin
            runBursts(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), -1, 0);
        end

        // Early wlast from m0 on a two-beat burst sets the sticky error.
        runBursts(2'b01, 2'b00, 1, 1);
        runBursts(2'b10, 2'b01, -1, 0);

        // Start a burst from m0 alone, then reset in the middle of its data phase.
        @(negedge clk_clk);
        applyStimulus(0, 3'd5, 30'h123, 8'd3, 0, 0, 0);
        m0_awvalid = 1; s_awready = 1; s_wready = 1; m0_wvalid = 1; m0_wlast = 0;
        #1 checkOutput("abort m0_awready", m0_awready, 1);
        @(negedge clk_clk);
        m0_awvalid = 0;
        #1 checkOutput("abort s_awvalid", s_awvalid, 1);
        @(negedge clk_clk);
        #1 checkOutput("abort s_wvalid", s_wvalid, 1);
        @(negedge clk_clk);
        #2;
        reset_reset_n = 0;
        m0_awvalid = 1; m1_awvalid = 1;
        #1;
        checkOutput("abort s_wvalid in reset", s_wvalid, 0);
        checkOutput("abort m0_wready in reset", m0_wready, 0);
        checkOutput("abort s_awvalid in reset", s_awvalid, 0);
        checkOutput("abort m0_awready in reset", m0_awready, 0);
        checkOutput("abort m1_awready in reset", m1_awready, 0);
        checkOutput("abort s_awlen in reset", s_awlen, 0);
        checkOutput("abort err_wlast in reset", err_wlast, 0);
        @(negedge clk_clk);
        reset_reset_n = 1;
        clearInputs();
        favorW = 0; favorR = 0; errExp = 0;
        runBursts(2'b11, 2'b00, 2, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
